// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multi-cycle main control unit. Steps each instruction through
//            IF/ID/EX/MEM/WB/PCINC and drives datapath enables, mux selects
//            and the 2-bit ALUOp. Stalls on mem_ready, latches HALT on ECALL.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted,
  output logic [2:0] state
);

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID    = 3'd1;
  localparam logic [2:0] S_EX    = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_PCINC = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  logic [2:0] state_q;
  logic [2:0] state_d;

  // Ungated decode; write enables are masked by reset below.
  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mdr_write;
  logic       w_reg_write;
  logic       w_mem_write;

  // Next-state and control decode from current state and opcode.
  always_comb begin
    state_d     = state_q;
    w_pc_write  = 1'b0;
    pc_source   = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_mdr_write = 1'b0;
    w_reg_write = 1'b0;
    wb_sel      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    is_halted   = 1'b0;

    case (state_q)
      S_IF: begin
        i_or_d   = 1'b0;
        mem_read = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          state_d    = S_ID;
        end
      end

      S_ID: begin
        // Branch/JAL target PC+imm is captured into ALUOut here.
        alu_src_a = 1'b0;
        alu_src_b = 2'b10;
        alu_op    = 2'b00;
        if (opcode == OP_ECALL) begin
          state_d = halt_req ? S_HALT : S_PCINC;
        end else if (opcode == OP_JAL) begin
          state_d = S_WB;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b00;
            state_d   = S_MEM;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b00;
            state_d   = S_WB;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b00;
            alu_op    = 2'b01;
            if (alu_bcond) begin
              // Taken branch retires here using the target held in ALUOut.
              w_pc_write = 1'b1;
              pc_source  = 1'b1;
              state_d    = S_IF;
            end else begin
              state_d = S_PCINC;
            end
          end
          default: begin
            // Unrecognised opcode behaves as a NOP.
            state_d = S_PCINC;
          end
        endcase
      end

      S_MEM: begin
        i_or_d      = 1'b1;
        mem_read    = (opcode == OP_LOAD);
        w_mem_write = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            w_mdr_write = 1'b1;
            state_d     = S_WB;
          end else begin
            state_d = S_PCINC;
          end
        end
      end

      S_WB: begin
        // ALU produces PC+4 for both the link value and the sequential PC.
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b01;
        alu_op      = 2'b00;
        if (opcode == OP_LOAD) begin
          wb_sel = 2'b01;
        end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
          wb_sel    = 2'b10;
          pc_source = 1'b1;
        end
        state_d = S_IF;
      end

      S_PCINC: begin
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b01;
        alu_op     = 2'b00;
        w_pc_write = 1'b1;
        pc_source  = 1'b0;
        state_d    = S_IF;
      end

      S_HALT: begin
        is_halted = 1'b1;
        state_d   = S_HALT;
      end

      default: begin
        // Unused encoding: recover by refetching.
        state_d = S_IF;
      end
    endcase
  end

  // State register with synchronous reset to IF.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // No architectural write may fire while reset is held, whatever the state.
  assign pc_write  = w_pc_write  & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign mdr_write = w_mdr_write & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Self-checking bench for mc_control_fsm. Each cycle the expected
//            state and control vector are queued with the stimulus and then
//            popped and compared against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID    = 3'd1;
  localparam logic [2:0] S_EX    = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_PCINC = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       mem_ready;
  logic       halt_req;
  logic       pc_write;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mdr_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_halted;
  logic [2:0] state;

  int n_vec;
  int n_err;

  logic [18:0] sb_q[$];

  mc_control_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .alu_bcond (alu_bcond),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .pc_write  (pc_write),
    .pc_source (pc_source),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .mdr_write (mdr_write),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .is_halted (is_halted),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector layout:
  // {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write,
  //  reg_write, wb_sel[1:0], alu_src_a, alu_src_b[1:0], alu_op[1:0], is_halted}
  function automatic logic [15:0] mk(input logic pcw, input logic pcs,
                                     input logic iod, input logic mr,
                                     input logic mw, input logic irw,
                                     input logic mdrw, input logic rw,
                                     input logic [1:0] wb, input logic a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic h);
    return {pcw, pcs, iod, mr, mw, irw, mdrw, rw, wb, a, b, op, h};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-low-phase, queue expectation, compare.
  task automatic step(input string tag, input logic rst, input logic [6:0] opc,
                      input logic bc, input logic rdy, input logic hr,
                      input logic [2:0] es, input logic [15:0] ec);
    logic [18:0] e;
    @(negedge clk);
    reset     = rst;
    opcode    = opc;
    alu_bcond = bc;
    mem_ready = rdy;
    halt_req  = hr;
    sb_q.push_back({es, ec});
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".state"}, {13'd0, state}, {13'd0, e[18:16]});
      check_eq({tag, ".ctl"},
               {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                mdr_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                is_halted},
               e[15:0]);
    end
  endtask

  logic [15:0] v_if_wait, v_if_go, v_id, v_ex_r, v_ex_i, v_ex_ma, v_ex_bt;
  logic [15:0] v_ex_bn, v_zero, v_mem_ld, v_mem_ld_go, v_mem_st, v_mem_st_rst;
  logic [15:0] v_wb_alu, v_wb_ld, v_wb_j, v_pcinc, v_halt;

  initial begin
    n_vec = 0;
    n_err = 0;
    //                 pcw pcs iod mr mw irw mdr rw  wb   a  b     op    h
    v_if_wait    = mk(0, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    v_if_go      = mk(0, 0, 0, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    v_id         = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 2'd0, 0);
    v_ex_r       = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd2, 0);
    v_ex_i       = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd2, 0);
    v_ex_ma      = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd0, 0);
    v_ex_bt      = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0);
    v_ex_bn      = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0);
    v_zero       = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    v_mem_ld     = mk(0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    v_mem_ld_go  = mk(0, 0, 1, 1, 0, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    v_mem_st     = mk(0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    v_mem_st_rst = mk(0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    v_wb_alu     = mk(1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd1, 2'd0, 0);
    v_wb_ld      = mk(1, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd1, 2'd0, 0);
    v_wb_j       = mk(1, 1, 0, 0, 0, 0, 0, 1, 2'd2, 0, 2'd1, 2'd0, 0);
    v_pcinc      = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0);
    v_halt       = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1);

    reset     = 1'b1;
    opcode    = OP_BAD;
    alu_bcond = 1'b0;
    mem_ready = 1'b0;
    halt_req  = 1'b0;

    // Reset held two cycles; ir_write must stay low even with mem_ready up.
    step("rst0", 1, OP_BAD, 0, 1, 0, S_IF, v_if_wait);
    step("rst1", 1, OP_BAD, 0, 1, 0, S_IF, v_if_wait);

    // add: 0,1,2,4
    step("add.if", 0, OP_R, 0, 1, 0, S_IF, v_if_go);
    step("add.id", 0, OP_R, 0, 1, 0, S_ID, v_id);
    step("add.ex", 0, OP_R, 0, 1, 0, S_EX, v_ex_r);
    step("add.wb", 0, OP_R, 0, 1, 0, S_WB, v_wb_alu);

    // lw with three MEM stall cycles: 8 cycles total
    step("lw.if", 0, OP_LOAD, 0, 1, 0, S_IF, v_if_go);
    step("lw.id", 0, OP_LOAD, 0, 1, 0, S_ID, v_id);
    step("lw.ex", 0, OP_LOAD, 0, 1, 0, S_EX, v_ex_ma);
    for (int i = 0; i < 3; i++)
      step("lw.memwait", 0, OP_LOAD, 0, 0, 0, S_MEM, v_mem_ld);
    step("lw.mem", 0, OP_LOAD, 0, 1, 0, S_MEM, v_mem_ld_go);
    step("lw.wb", 0, OP_LOAD, 0, 1, 0, S_WB, v_wb_ld);

    // beq taken (3 cycles), then not taken (4 cycles)
    step("beqt.if", 0, OP_BRANCH, 1, 1, 0, S_IF, v_if_go);
    step("beqt.id", 0, OP_BRANCH, 1, 1, 0, S_ID, v_id);
    step("beqt.ex", 0, OP_BRANCH, 1, 1, 0, S_EX, v_ex_bt);
    step("beqn.if", 0, OP_BRANCH, 0, 1, 0, S_IF, v_if_go);
    step("beqn.id", 0, OP_BRANCH, 0, 1, 0, S_ID, v_id);
    step("beqn.ex", 0, OP_BRANCH, 0, 1, 0, S_EX, v_ex_bn);
    step("beqn.pc", 0, OP_BRANCH, 0, 1, 0, S_PCINC, v_pcinc);

    // jal: 0,1,4
    step("jal.if", 0, OP_JAL, 0, 1, 0, S_IF, v_if_go);
    step("jal.id", 0, OP_JAL, 0, 1, 0, S_ID, v_id);
    step("jal.wb", 0, OP_JAL, 0, 1, 0, S_WB, v_wb_j);

    // addi with one fetch stall
    step("addi.ifw", 0, OP_I, 0, 0, 0, S_IF, v_if_wait);
    step("addi.if", 0, OP_I, 0, 1, 0, S_IF, v_if_go);
    step("addi.id", 0, OP_I, 0, 1, 0, S_ID, v_id);
    step("addi.ex", 0, OP_I, 0, 1, 0, S_EX, v_ex_i);
    step("addi.wb", 0, OP_I, 0, 1, 0, S_WB, v_wb_alu);

    // jalr
    step("jalr.if", 0, OP_JALR, 0, 1, 0, S_IF, v_if_go);
    step("jalr.id", 0, OP_JALR, 0, 1, 0, S_ID, v_id);
    step("jalr.ex", 0, OP_JALR, 0, 1, 0, S_EX, v_ex_ma);
    step("jalr.wb", 0, OP_JALR, 0, 1, 0, S_WB, v_wb_j);

    // unknown opcode acts as NOP
    step("nop.if", 0, OP_BAD, 0, 1, 0, S_IF, v_if_go);
    step("nop.id", 0, OP_BAD, 0, 1, 0, S_ID, v_id);
    step("nop.ex", 0, OP_BAD, 0, 1, 0, S_EX, v_zero);
    step("nop.pc", 0, OP_BAD, 0, 1, 0, S_PCINC, v_pcinc);

    // ecall without halt: 3 cycles
    step("ecn.if", 0, OP_ECALL, 0, 1, 0, S_IF, v_if_go);
    step("ecn.id", 0, OP_ECALL, 0, 1, 0, S_ID, v_id);
    step("ecn.pc", 0, OP_ECALL, 0, 1, 0, S_PCINC, v_pcinc);

    // sw, normal: IF ID EX MEM PCINC
    step("sw.if", 0, OP_STORE, 0, 1, 0, S_IF, v_if_go);
    step("sw.id", 0, OP_STORE, 0, 1, 0, S_ID, v_id);
    step("sw.ex", 0, OP_STORE, 0, 1, 0, S_EX, v_ex_ma);
    step("sw.mem", 0, OP_STORE, 0, 1, 0, S_MEM, v_mem_st);
    step("sw.pc", 0, OP_STORE, 0, 1, 0, S_PCINC, v_pcinc);

    // sw with reset during MEM: mem_write forced low, then IF
    step("swr.if", 0, OP_STORE, 0, 1, 0, S_IF, v_if_go);
    step("swr.id", 0, OP_STORE, 0, 1, 0, S_ID, v_id);
    step("swr.ex", 0, OP_STORE, 0, 1, 0, S_EX, v_ex_ma);
    step("swr.memw", 0, OP_STORE, 0, 0, 0, S_MEM, v_mem_st);
    step("swr.rst", 1, OP_STORE, 0, 1, 0, S_MEM, v_mem_st_rst);
    step("swr.after", 0, OP_STORE, 0, 0, 0, S_IF, v_if_wait);

    // ecall with halt_req: HALT sticks, then reset returns to IF
    step("ech.if", 0, OP_ECALL, 0, 1, 1, S_IF, v_if_go);
    step("ech.id", 0, OP_ECALL, 0, 1, 1, S_ID, v_id);
    for (int i = 0; i < 12; i++)
      step("ech.halt", 0, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
           1'b1, 1'b0, S_HALT, v_halt);
    step("ech.rst", 1, OP_R, 0, 1, 0, S_HALT, v_halt);
    step("ech.after", 0, OP_R, 0, 0, 0, S_IF, v_if_wait);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control unit for the RISC-V core. Sequences each instruction through fetch, decode, execute, memory and writeback states and drives the datapath enables, the mux selects, and the 2-bit ALUOp consumed by the ALU control unit. It sits between the instruction register's opcode field and the shared ALU / unified memory datapath. It waits on a memory ready handshake and latches a halt on ECALL.

## Interface
- No parameters. State encoding is fixed: IF=0, ID=1, EX=2, MEM=3, WB=4, PCINC=5, HALT=6.
- clk  in  1  clock; all state updates occur on the rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  IR[6:0]; valid from ID onward.
- alu_bcond  in  1  branch condition from the ALU; sampled in EX.
- mem_ready  in  1  memory completed the current access this cycle.
- halt_req  in  1  datapath asserts when opcode is ECALL and x17==10.
- pc_write  out  1  PC load enable.
- pc_source  out  1  next-PC select: 0 = ALU result, 1 = ALUOut register.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  IR load enable.
- mdr_write  out  1  MDR load enable.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  writeback data select: 00 = ALUOut, 01 = MDR, 10 = ALU result.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct.
- is_halted  out  1  high in HALT.
- state  out  3  current state, for debug.

## Operation
- Outputs are a combinational decode of state and opcode. Any output not listed for a state is 0.
- The datapath latches ALUOut, A and B every cycle.
- IF: i_or_d=0, mem_read=1. Wait while mem_ready=0. When mem_ready=1: ir_write=1 and go to ID.
- ID: alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut <= PC+imm.
  - ECALL (1110011) with halt_req: go to HALT.
  - ECALL without halt_req: go to PCINC.
  - JAL (1101111): go to WB.
  - Any other opcode: go to EX.
- EX, by opcode:
  - R-type (0110011): a=1, b=00, alu_op=10; go to WB.
  - I-arith (0010011): a=1, b=10, alu_op=10; go to WB.
  - LOAD (0000011) or STORE (0100011): a=1, b=10, alu_op=00; go to MEM.
  - JALR (1100111): a=1, b=10, alu_op=00; go to WB.
  - BRANCH (1100011): a=1, b=00, alu_op=01.
    - alu_bcond=1: pc_write=1, pc_source=1 (target held in ALUOut since ID); go to IF.
    - alu_bcond=0: go to PCINC.
  - Unknown opcode: treated as NOP; go to PCINC.
- MEM: i_or_d=1. LOAD asserts mem_read; STORE asserts mem_write. Hold while mem_ready=0.
  - On mem_ready with LOAD: mdr_write=1; go to WB.
  - On mem_ready with STORE: go to PCINC.
- WB: reg_write=1 and pc_write=1; ALU computes PC+4 (a=0, b=01, alu_op=00). Go to IF.
  - R-type and I-arith: wb_sel=00, pc_source=0.
  - LOAD: wb_sel=01, pc_source=0.
  - JAL and JALR: wb_sel=10 (link = PC+4), pc_source=1 (ALUOut target). Clearing JALR target bit 0 is the datapath's job.
- PCINC: a=0, b=01, alu_op=00, pc_write=1, pc_source=0. Go to IF.
- HALT: all enables and strobes 0, is_halted=1. Stays in HALT until reset.

## Timing
- Reset: on a clk edge with reset=1, state <= IF.
  - While reset=1, pc_write, ir_write, mdr_write, reg_write and mem_write are forced to 0.
  - The first cycle after reset is IF, so mem_read=1 and is_halted=0.
- Reset mid-instruction, including in MEM or HALT: the instruction is abandoned and no write enable fires during the reset cycle.
- Cycles per instruction with mem_ready tied high:
  - R-type, I-arith, JALR: 4.
  - LOAD: 5.
  - STORE: 5 (IF, ID, EX, MEM, PCINC).
  - BRANCH taken: 3; not taken: 4.
  - JAL: 3.
  - ECALL without halt: 3.
- Each cycle with mem_ready=0 in IF or MEM adds exactly one cycle.
- Strobes, addresses and selects stay constant throughout a stall.
- ir_write and mdr_write pulse for exactly one cycle: the cycle mem_ready=1.
- Exactly one pc_write pulse per retired instruction. reg_write is at most one cycle per instruction.
- mem_ready asserted in any state other than IF or MEM is ignored.

## Test plan
- Reset held 2 cycles, then add x3,x1,x2 (opcode 0110011) with mem_ready=1 -> states 0,1,2,4,0. alu_op=10 in EX. WB has reg_write=1, wb_sel=00, pc_write=1, pc_source=0.
- lw (0000011) with mem_ready low for 3 MEM cycles -> MEM held 4 cycles with i_or_d=1 and mem_read=1. mdr_write for one cycle. WB with wb_sel=01. Total 8 cycles.
- beq (1100011): alu_bcond=1 -> EX has pc_write=1, pc_source=1, then IF (3 cycles). With alu_bcond=0 -> PCINC, then IF (4 cycles).
- jal (1101111) -> states 0,1,4. WB has wb_sel=10, pc_source=1, reg_write=1.
- ecall (1110011) with halt_req=1 -> HALT after ID, is_halted=1 held 10+ cycles with every enable 0. Reset -> IF with is_halted=0.
- sw (0100011) with reset asserted during MEM -> mem_write forced 0 in the reset cycle, next state IF.
